// File: rtl/kbd_pkg.sv
// Shared constants and types for the PS/2 keyboard scan front end.
package kbd_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned BIT_CNT_W      = 4;
  localparam int unsigned DATA_BITS      = 8;

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] EXT_PREFIX   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    BREAK   = 2'd2
  } kbd_state_e;

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchroniser, falling-edge detect,
// 11-bit deserialiser with start/parity/stop checks and inter-bit timeout.
module ps2_frame_rx
  import kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]     TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_START = BIT_CNT_W'(0);
  localparam logic [BIT_CNT_W-1:0] BIT_D7    = BIT_CNT_W'(DATA_BITS);
  localparam logic [BIT_CNT_W-1:0] BIT_PAR   = BIT_CNT_W'(DATA_BITS + 1);
  localparam logic [BIT_CNT_W-1:0] BIT_STOP  = BIT_CNT_W'(PS2_FRAME_BITS - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   start_ok_q, start_ok_d;
  logic                   parity_q, parity_d;
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                   rx_valid_q, rx_valid_d;
  logic [7:0]             rx_byte_q, rx_byte_d;
  logic                   frame_err_q, frame_err_d;

  logic clk_synced_c;
  logic data_bit_c;
  logic fall_c;
  logic frame_good_c;

  assign clk_synced_c = clk_sync_q[SYNC_STAGES-1];
  assign data_bit_c   = data_sync_q[SYNC_STAGES-1];
  assign fall_c       = clk_prev_q & ~clk_synced_c;
  assign frame_good_c = start_ok_q & data_bit_c & odd_parity_ok(shift_q, parity_q);

  // Next-state logic for the synchroniser, deserialiser and timeout.
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d  = clk_synced_c;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    start_ok_d  = start_ok_q;
    parity_d    = parity_q;
    tmo_cnt_d   = tmo_cnt_q;
    rx_valid_d  = 1'b0;
    rx_byte_d   = rx_byte_q;
    frame_err_d = 1'b0;

    if (fall_c) begin
      tmo_cnt_d = '0;
      if (bit_cnt_q == BIT_START) begin
        start_ok_d = ~data_bit_c;
      end else if (bit_cnt_q <= BIT_D7) begin
        shift_d = {data_bit_c, shift_q[7:1]};
      end else if (bit_cnt_q == BIT_PAR) begin
        parity_d = data_bit_c;
      end

      if (bit_cnt_q == BIT_STOP) begin
        bit_cnt_d = '0;
        if (frame_good_c) begin
          rx_valid_d = 1'b1;
          rx_byte_d  = shift_q;
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
      end
    end else if (bit_cnt_q == BIT_START) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == TMO_LAST) begin
      // A stalled partial frame is dropped so the next start bit is clean.
      bit_cnt_d   = '0;
      tmo_cnt_d   = '0;
      frame_err_d = 1'b1;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  // Receiver state registers; synchroniser idles high like the PS/2 bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      start_ok_q  <= 1'b0;
      parity_q    <= 1'b0;
      tmo_cnt_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_byte_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      start_ok_q  <= start_ok_d;
      parity_q    <= parity_d;
      tmo_cnt_q   <= tmo_cnt_d;
      rx_valid_q  <= rx_valid_d;
      rx_byte_q   <= rx_byte_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_valid  = rx_valid_q;
  assign rx_byte   = rx_byte_q;
  assign frame_err = frame_err_q;

endmodule

// File: rtl/kbd_scan_ctrl.sv
// PS/2 keyboard front end: frame receiver plus make/break/typematic tracker
// presenting the held key's scan code, a held flag and a press counter.
module kbd_scan_ctrl
  import kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       key_valid,
  output logic [7:0] key_count,
  output logic       frame_err
);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_frame_err;

  kbd_state_e state_q, state_d;
  logic [7:0] scan_code_q, scan_code_d;
  logic       key_valid_q, key_valid_d;
  logic [7:0] key_count_q, key_count_d;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .frame_err (rx_frame_err)
  );

  // Make/break tracking; extended prefixes are swallowed in every state.
  always_comb begin
    state_d     = state_q;
    scan_code_d = scan_code_q;
    key_valid_d = key_valid_q;
    key_count_d = key_count_q;

    if (rx_valid && (rx_byte != EXT_PREFIX)) begin
      unique case (state_q)
        IDLE: begin
          if (rx_byte == BREAK_PREFIX) begin
            state_d = BREAK;
          end else begin
            state_d     = PRESSED;
            scan_code_d = rx_byte;
            key_valid_d = 1'b1;
            key_count_d = key_count_q + 8'd1;
          end
        end
        PRESSED: begin
          if (rx_byte == BREAK_PREFIX) begin
            state_d = BREAK;
          end else if (rx_byte != scan_code_q) begin
            scan_code_d = rx_byte;
            key_count_d = key_count_q + 8'd1;
          end
        end
        BREAK: begin
          if (rx_byte == scan_code_q) begin
            state_d     = IDLE;
            key_valid_d = 1'b0;
          end else begin
            // Release of some other key: return to where we were.
            state_d = key_valid_q ? PRESSED : IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Tracker registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      scan_code_q <= 8'h00;
      key_valid_q <= 1'b0;
      key_count_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      scan_code_q <= scan_code_d;
      key_valid_q <= key_valid_d;
      key_count_q <= key_count_d;
    end
  end

  assign scan_code = scan_code_q;
  assign key_valid = key_valid_q;
  assign key_count = key_count_q;
  assign frame_err = rx_frame_err;

endmodule
